// File: rtl/dbram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbram_arbiter_pkg
//  Description : Shared types and configuration for the dual-core data-BRAM
//                arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dbram_arbiter_pkg;

    localparam int DBRAM_LOCK_MAX = 16;

    typedef enum logic [1:0] {
        ARB_RR    = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } dbram_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dbram_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant2
//  Description : Combinational two-way round-robin grant; prio names the core
//                that wins when both request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dbram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dbram_arbiter
//  Description : Shares one local data BRAM between two cores' load/store
//                units; round-robin with a bounded per-core lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbram_arbiter
    import dbram_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = DBRAM_LOCK_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0][31:0] addr,
    input  logic [1:0][3:0]  be,
    input  logic [1:0][31:0] wdata,
    input  logic [1:0]       load,
    input  logic [1:0]       lock,
    output logic [1:0]       ready,
    output logic [1:0]       data_valid,
    output logic [31:0]      rdata,
    output logic [29:0]      bram_addr,
    output logic             bram_en,
    output logic [3:0]       bram_be,
    output logic [31:0]      bram_data_in,
    input  logic [31:0]      bram_data_out
);

    localparam int                 C_CNT_W    = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(LOCK_MAX - 1);

    dbram_arb_state_t   r_state;
    dbram_arb_state_t   w_state_nxt;
    logic               r_prio;
    logic               w_prio_nxt;
    logic [C_CNT_W-1:0] r_lock_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [1:0]         w_rr_grant;
    logic [1:0]         w_acc;
    logic               w_sel;
    logic               w_owner;
    logic               w_unused_addr_lsb;

    rr_grant2 u_rr_grant2 (
        .req   (req),
        .prio  (r_prio),
        .grant (w_rr_grant)
    );

    always_comb begin
        ready = 2'b00;
        unique case (r_state)
            ARB_RR:    ready = w_rr_grant;
            ARB_LOCK0: ready[0] = req[0];
            ARB_LOCK1: ready[1] = req[1];
            default:   ready = 2'b00;
        endcase
    end

    // At most one accept bit is set, so the upper bit picks the port.
    assign w_acc   = req & ready;
    assign w_sel   = w_acc[1];
    assign w_owner = (r_state == ARB_LOCK1);

    assign bram_en           = |w_acc;
    assign bram_addr         = addr[w_sel][31:2];
    assign bram_be           = be[w_sel];
    assign bram_data_in      = wdata[w_sel];
    assign rdata             = bram_data_out;
    assign w_unused_addr_lsb = ^{addr[0][1:0], addr[1][1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_lock_cnt;
        unique case (r_state)
            ARB_RR: begin
                if (|w_acc) begin
                    if (lock[w_sel]) begin
                        w_state_nxt = w_sel ? ARB_LOCK1 : ARB_LOCK0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_prio_nxt = ~w_sel;
                    end
                end
            end
            ARB_LOCK0, ARB_LOCK1: begin
                w_cnt_nxt = r_lock_cnt + C_CNT_W'(1);
                // Timeout releases even if the owner asked to keep the lock.
                if ((r_lock_cnt == C_CNT_LAST) || (w_acc[w_owner] && !lock[w_owner])) begin
                    w_state_nxt = ARB_RR;
                    w_prio_nxt  = ~w_owner;
                end
            end
            default: w_state_nxt = ARB_RR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_RR;
            r_prio     <= 1'b0;
            r_lock_cnt <= '0;
            data_valid <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_lock_cnt <= w_cnt_nxt;
            data_valid <= w_acc & load;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbram_arbiter
//  Description : Directed vector bench for dbram_arbiter with LOCK_MAX=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbram_arbiter;

    localparam logic [31:0] C_A0 = 32'hFFFF_FF01;
    localparam logic [31:0] C_A1 = 32'h0000_0203;
    localparam logic [3:0]  C_B0 = 4'hF;
    localparam logic [3:0]  C_B1 = 4'h6;
    localparam logic [31:0] C_W0 = 32'hA5A5_0000;
    localparam logic [31:0] C_W1 = 32'h0000_5A5A;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0][31:0] addr;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata;
    logic [1:0]       load;
    logic [1:0]       lock;
    logic [1:0]       ready;
    logic [1:0]       data_valid;
    logic [31:0]      rdata;
    logic [29:0]      bram_addr;
    logic             bram_en;
    logic [3:0]       bram_be;
    logic [31:0]      bram_data_in;
    logic [31:0]      bram_data_out;

    dbram_arbiter #(.LOCK_MAX(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .addr          (addr),
        .be            (be),
        .wdata         (wdata),
        .load          (load),
        .lock          (lock),
        .ready         (ready),
        .data_valid    (data_valid),
        .rdata         (rdata),
        .bram_addr     (bram_addr),
        .bram_en       (bram_en),
        .bram_be       (bram_be),
        .bram_data_in  (bram_data_in),
        .bram_data_out (bram_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  load;
        logic [1:0]  lock;
        logic [31:0] bdo;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_dv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic [1:0] r, input logic [1:0] ld, input logic [1:0] lk,
                       input logic [31:0] bdo, input logic [1:0] er, input logic [1:0] edv,
                       input logic [31:0] erd);
        vec_t v;
        v.req = r; v.load = ld; v.lock = lk; v.bdo = bdo;
        v.exp_ready = er; v.exp_dv = edv; v.exp_rdata = erd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] ld, input logic [1:0] lk,
                         input logic [31:0] bdo);
        req = r; load = ld; lock = lk; bram_data_out = bdo;
    endtask

    initial begin
        addr  = '{C_A1, C_A0};
        be    = '{C_B1, C_B0};
        wdata = '{C_W1, C_W0};
        drive(2'b00, 2'b00, 2'b00, 32'h0);
        rst_n = 1'b0;

        //   req    load   lock   bdo            ready  dv     rdata
        add(2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 2'b00, 32'h0);        // idle after reset
        add(2'b11, 2'b11, 2'b00, 32'h0,         2'b01, 2'b00, 32'h0);        // contention: 0,1,0,1
        add(2'b11, 2'b11, 2'b00, 32'h1111_0001, 2'b10, 2'b01, 32'h1111_0001);
        add(2'b11, 2'b11, 2'b00, 32'h1111_0002, 2'b01, 2'b10, 32'h1111_0002);
        add(2'b11, 2'b11, 2'b00, 32'h1111_0003, 2'b10, 2'b01, 32'h1111_0003);
        add(2'b00, 2'b00, 2'b00, 32'h1111_0004, 2'b00, 2'b10, 32'h1111_0004);
        add(2'b01, 2'b01, 2'b00, 32'h0,         2'b01, 2'b00, 32'h0);        // single load
        add(2'b00, 2'b00, 2'b00, 32'hDEAD_BEEF, 2'b00, 2'b01, 32'hDEAD_BEEF);
        add(2'b11, 2'b01, 2'b10, 32'h0,         2'b10, 2'b00, 32'h0);        // core1 locked store
        add(2'b11, 2'b01, 2'b10, 32'h0,         2'b10, 2'b00, 32'h0);
        add(2'b01, 2'b01, 2'b00, 32'h0,         2'b00, 2'b00, 32'h0);
        add(2'b11, 2'b01, 2'b00, 32'h0,         2'b10, 2'b00, 32'h0);        // release
        add(2'b01, 2'b01, 2'b00, 32'h0,         2'b01, 2'b00, 32'h0);
        add(2'b00, 2'b00, 2'b00, 32'hCAFE_F00D, 2'b00, 2'b01, 32'hCAFE_F00D);
        add(2'b01, 2'b00, 2'b01, 32'h0,         2'b01, 2'b00, 32'h0);        // core0 locks, drops req
        add(2'b10, 2'b10, 2'b00, 32'h0,         2'b00, 2'b00, 32'h0);
        add(2'b10, 2'b10, 2'b00, 32'h0,         2'b00, 2'b00, 32'h0);
        add(2'b10, 2'b10, 2'b00, 32'h0,         2'b00, 2'b00, 32'h0);
        add(2'b10, 2'b10, 2'b00, 32'h0,         2'b00, 2'b00, 32'h0);        // timeout cycle
        add(2'b10, 2'b10, 2'b00, 32'h0,         2'b10, 2'b00, 32'h0);
        add(2'b00, 2'b00, 2'b00, 32'h1234_5678, 2'b00, 2'b10, 32'h1234_5678);
        add(2'b01, 2'b00, 2'b01, 32'h0,         2'b01, 2'b00, 32'h0);        // lock held to timeout
        add(2'b11, 2'b00, 2'b01, 32'h0,         2'b01, 2'b00, 32'h0);
        add(2'b11, 2'b00, 2'b01, 32'h0,         2'b01, 2'b00, 32'h0);
        add(2'b11, 2'b00, 2'b01, 32'h0,         2'b01, 2'b00, 32'h0);
        add(2'b11, 2'b01, 2'b01, 32'h0,         2'b01, 2'b00, 32'h0);        // accept on timeout
        add(2'b11, 2'b11, 2'b00, 32'h5555_AAAA, 2'b10, 2'b01, 32'h5555_AAAA);
        add(2'b00, 2'b00, 2'b00, 32'h6666_BBBB, 2'b00, 2'b10, 32'h6666_BBBB);
        add(2'b01, 2'b00, 2'b00, 32'h0,         2'b01, 2'b00, 32'h0);        // set prio=1
        add(2'b11, 2'b10, 2'b00, 32'h0,         2'b10, 2'b00, 32'h0);        // store0 vs load1
        add(2'b01, 2'b10, 2'b00, 32'h7777_CCCC, 2'b01, 2'b10, 32'h7777_CCCC);
        add(2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 2'b00, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        chk("reset_ready", -1, 32'(ready), 32'h0);
        chk("reset_dv",    -1, 32'(data_valid), 32'h0);
        chk("reset_en",    -1, 32'(bram_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            logic [1:0]  er;
            logic        s1;
            er = vecs[i].exp_ready;
            s1 = er[1];
            drive(vecs[i].req, vecs[i].load, vecs[i].lock, vecs[i].bdo);
            #1;
            n_vec++;
            chk("ready",     i, 32'(ready), 32'(er));
            chk("bram_en",   i, 32'(bram_en), 32'(|er));
            chk("bram_addr", i, 32'(bram_addr), s1 ? 32'(C_A1[31:2]) : 32'(C_A0[31:2]));
            chk("bram_be",   i, 32'(bram_be), s1 ? 32'(C_B1) : 32'(C_B0));
            chk("bram_din",  i, bram_data_in, s1 ? C_W1 : C_W0);
            chk("data_valid", i, 32'(data_valid), 32'(vecs[i].exp_dv));
            if (vecs[i].exp_dv != 2'b00)
                chk("rdata", i, rdata, vecs[i].exp_rdata);
            @(negedge clk);
        end

        // Reset while locked to core1 with a load just accepted.
        drive(2'b10, 2'b10, 2'b10, 32'h0);
        #1;
        n_vec++;
        chk("rst_seq_grant1", 100, 32'(ready), 32'h2);
        @(negedge clk);
        drive(2'b11, 2'b11, 2'b10, 32'h0);
        #1;
        n_vec++;
        chk("rst_seq_locked", 101, 32'(ready), 32'h2);
        chk("rst_seq_dv",     101, 32'(data_valid), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("rst_async_dv",    102, 32'(data_valid), 32'h0);
        chk("rst_async_ready", 102, 32'(ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 2'b11, 2'b00, 32'h0);
        #1;
        n_vec++;
        chk("post_rst_ready", 103, 32'(ready), 32'h1);
        chk("post_rst_dv",    103, 32'(data_valid), 32'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0BAD_F00D);
        #1;
        n_vec++;
        chk("post_rst_dv2",   104, 32'(data_valid), 32'h1);
        chk("post_rst_rdata", 104, rdata, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
